hdr_action_engine: RTL
======================

# hdr_action_engine

Parametrised packet-header action engine: runs a short per-flow program of 64-bit primitives against a byte-array header held in the pipeline stage after the parser. It replaces the fixed single-width executor with configurable header, table, argument and header-slot sizes. It adds a multi-byte big-endian ADD, multi-beat COPY_FIELD, and an inline 16-bit one's-complement checksum. It drives egress metadata (port, multicast group, recirculate) and reports an error on out-of-range accesses.

## Interface
- HDR_LEN, 128: header buffer bytes; byte address width AW = $clog2(HDR_LEN).
- OP_NUM, 16: op table depth; index width OW = $clog2(OP_NUM).
- ARG_LEN, 16: action-argument bytes.
- NUM_HDRS, 16: parsed-header slots; must be ≤16 (4-bit hdr field).
- COPY_BPC, 4: bytes moved per cycle by COPY_FIELD; must be 1, 2, 4 or 8.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start_i  in  1  begin program; sampled only in IDLE.
- pkt_hdr_i  in  8×HDR_LEN  input header.
- op_start_i  in  OW  first op index.
- args_i  in  8×ARG_LEN  action arguments (HDR_PARAM source).
- parsed_hdrs_i  in  AW×NUM_HDRS  header base byte offsets; must be stable from start_i until ready_o.
- mod_start_i  in  1  load op table; priority over start_i.
- mod_ops_i  in  64×OP_NUM  new op table.
- ready_o  out  1  one-cycle done pulse.
- busy_o  out  1  high outside IDLE.
- err_o  out  1  valid with ready_o; 1 = aborted.
- pkt_hdr_o  out  8×HDR_LEN  result header; held until next accepted start.
- port_o / port_vld_o  out  8 / 1  egress port.
- mcast_o / mcast_vld_o  out  16 / 1  multicast group.
- recirc_o  out  1  recirculate request.

## Operation
- Op format: opcode[63:58], imm[57:32] (26-bit signed), f1_hdr[31:28], f1_off[27:22], f1_len[21:16], f2_hdr[15:12], f2_off[11:6], f2_len[5:0]. Opcodes use the `OPCODE_*` macros.
- f1_start = parsed_hdrs_i[f1_hdr] + f1_off; f2_start is formed the same way. Both are computed at AW+1 bits.
- States: IDLE, EXEC, BEAT (multi-cycle COPY/CKSUM), CKFIN.
- IDLE:
  - mod_start_i: ops ← mod_ops_i; stay IDLE.
  - Otherwise start_i: pkt_hdr_o ← pkt_hdr_i; inst ← ops[op_start_i]; pc ← op_start_i+1; clear port/mcast/recirc/err; go to EXEC.
- Fetch-next rule: if pc == OP_NUM, finish OK (implicit NOP). Otherwise inst ← ops[pc] and pc increments.
- NOP or unknown opcode: finish; err_o = 1 for an unknown opcode.
- ADD:
  - f1_len 0: no-op.
  - f1_len 1..4: big-endian field of f1_len bytes at f1_start ← (field + sign-extended imm) mod 2^(8·f1_len).
  - f1_len > 4: error.
  - Takes 1 cycle.
- COPY_FIELD:
  - Moves f1_len bytes, COPY_BPC bytes per beat.
  - Source is args_i[f2_off+i] when f2_hdr == HDR_PARAM, else pkt_hdr_o[f2_start+i].
  - Each beat reads values as they were before that beat.
  - Duration ceil(f1_len/COPY_BPC) cycles, minimum 1.
- CKSUM:
  - Entry cycle zeroes 2 bytes at f2_start.
  - BEAT sums 16-bit big-endian words over f1_len bytes at f1_start, one word per cycle, with end-around carry. An odd final byte is padded with 0x00 low.
  - CKFIN writes ~sum at f2_start (MSB first).
  - Duration 1 + ceil(f1_len/2) + 1 cycles.
- SET_PORT: port_o ← imm[7:0], port_vld_o ← 1.
- SET_MULTICAST: mcast_o ← imm[15:0], mcast_vld_o ← 1.
- RECIRCULATE: recirc_o ← 1.
- Each SET/RECIRCULATE op takes 1 cycle and continues.
- Bounds: any write or packet read address ≥ HDR_LEN, or arg index ≥ ARG_LEN, aborts the op with no partial write: err_o ← 1, finish. Earlier ops' effects are kept.
- Finish: ready_o pulses for 1 cycle; go to IDLE. Metadata outputs hold until the next accepted start.

## Timing
- Reset (rst = 0, asynchronous):
  - Outputs: ready_o, busy_o, err_o, pkt_hdr_o, port_o, port_vld_o, mcast_o, mcast_vld_o, recirc_o all 0.
  - Internal: state IDLE; op table all zero, so a program is NOP.
- Reset mid-program aborts immediately; no ready_o is issued.
- Latency from the start_i edge to ready_o high = 1 + Σ(op cycles), where the terminating NOP counts 1.
- busy_o is high from the cycle after start acceptance until the ready_o cycle inclusive.
- start_i or mod_start_i while busy: ignored, not queued.
- Same-cycle mod_start_i and start_i in IDLE: table load only; start dropped.
- The new table is visible to a start issued on the next cycle.

## Test plan
- Program [NOP]; start → ready_o on the 2nd cycle after start, err_o = 0, pkt_hdr_o == pkt_hdr_i.
- ADD, f1_len = 2, field 0x00FF, imm = +1 → 0x0100. Repeat with field 0x0000, imm = −1 → 0xFFFF. Each completes in 1 cycle.
- COPY_FIELD with COPY_BPC = 4, f1_len = 6 from HDR_PARAM args 0xA0..A5 → bytes written, op takes 2 cycles.
- CKSUM over 20-byte IPv4 header 4500 0073 0000 4000 4011 0000 C0A8 0001 C0A8 00C7 → field = 0xB861, op takes 12 cycles.
- SET_PORT imm = 5, SET_MULTICAST imm = 0x1234, RECIRCULATE, NOP → port_o = 5, mcast_o = 0x1234, recirc_o = 1, all valids high at ready_o.
- COPY with f1_start = HDR_LEN−1, len 2 → err_o = 1, no bytes changed. Separately, rst = 0 mid-CKSUM → all outputs 0 immediately and no ready_o.

Source files
------------

// File: rtl/hdr_action_engine_if.sv
// rtl/hdr_action_engine_if.sv - handshake and data bundle for hdr_action_engine
//
// Opcode encodings shared by the engine and anything that builds op tables.
// The slave modport is the engine side. Fields:
//   start_i        begin a program (sampled only while idle)
//   pkt_hdr_i      input header, byte n at bits [8n+7:8n]
//   op_start_i     index of the first op to run
//   args_i         action arguments, byte n at bits [8n+7:8n]
//   parsed_hdrs_i  per-slot header base byte offsets, slot k at [AW*k +: AW]
//   mod_start_i    load op table from mod_ops_i (wins over start_i)
//   mod_ops_i      new op table, op k at [64k +: 64]
//   ready_o        one-cycle completion pulse
//   busy_o         program in flight, including the ready_o cycle
//   err_o          program aborted (valid with ready_o)
//   pkt_hdr_o      result header
//   port_o/port_vld_o, mcast_o/mcast_vld_o, recirc_o  egress metadata

`ifndef HDR_ACTION_ENGINE_OPCODES
`define HDR_ACTION_ENGINE_OPCODES
`define OPCODE_NOP           6'd0
`define OPCODE_ADD           6'd1
`define OPCODE_COPY_FIELD    6'd2
`define OPCODE_CKSUM         6'd3
`define OPCODE_SET_PORT      6'd4
`define OPCODE_SET_MULTICAST 6'd5
`define OPCODE_RECIRCULATE   6'd6
`endif

interface hdr_action_engine_if #(
  parameter int HDR_LEN  = 128,
  parameter int OP_NUM   = 16,
  parameter int ARG_LEN  = 16,
  parameter int NUM_HDRS = 16
);
  localparam int AW = $clog2(HDR_LEN);
  localparam int OW = $clog2(OP_NUM);

  logic                     start_i;
  logic [8*HDR_LEN-1:0]     pkt_hdr_i;
  logic [OW-1:0]            op_start_i;
  logic [8*ARG_LEN-1:0]     args_i;
  logic [AW*NUM_HDRS-1:0]   parsed_hdrs_i;
  logic                     mod_start_i;
  logic [64*OP_NUM-1:0]     mod_ops_i;
  logic                     ready_o;
  logic                     busy_o;
  logic                     err_o;
  logic [8*HDR_LEN-1:0]     pkt_hdr_o;
  logic [7:0]               port_o;
  logic                     port_vld_o;
  logic [15:0]              mcast_o;
  logic                     mcast_vld_o;
  logic                     recirc_o;

  modport master (
    output start_i, pkt_hdr_i, op_start_i, args_i, parsed_hdrs_i, mod_start_i, mod_ops_i,
    input  ready_o, busy_o, err_o, pkt_hdr_o, port_o, port_vld_o, mcast_o, mcast_vld_o,
           recirc_o
  );

  modport slave (
    input  start_i, pkt_hdr_i, op_start_i, args_i, parsed_hdrs_i, mod_start_i, mod_ops_i,
    output ready_o, busy_o, err_o, pkt_hdr_o, port_o, port_vld_o, mcast_o, mcast_vld_o,
           recirc_o
  );
endinterface

// File: rtl/hdr_action_engine.sv
// rtl/hdr_action_engine.sv - per-flow header action program executor
//
// Runs a program of 64-bit ops from a loadable table against a byte-array
// header: big-endian ADD, multi-beat COPY_FIELD, inline 16-bit one's-complement
// checksum, and egress metadata setters.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  hdr_action_engine_if.slave (start/table-load inputs, header, args,
//        slot offsets; ready/busy/err, result header, port/mcast/recirc)

module hdr_action_engine #(
  parameter int HDR_LEN  = 128,
  parameter int OP_NUM   = 16,
  parameter int ARG_LEN  = 16,
  parameter int NUM_HDRS = 16,
  parameter int COPY_BPC = 4
) (
  input  logic               clk,
  input  logic               rst,
  hdr_action_engine_if.slave bus
);
  localparam int         AW        = $clog2(HDR_LEN);
  localparam int         OW        = $clog2(OP_NUM);
  localparam logic [3:0] HDR_PARAM = 4'hF;   // f2_hdr value selecting args_i

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BEAT, S_CKFIN} state_t;

  state_t      state_q, state_d;
  logic [63:0] ops_q [OP_NUM];
  logic [63:0] ops_d [OP_NUM];
  logic [63:0] inst_q, inst_d;
  logic [OW:0] pc_q, pc_d;
  logic [6:0]  cnt_q, cnt_d;        // byte offset within the current multi-beat op
  logic [15:0] sum_q, sum_d;
  logic [7:0]  hdr_q [HDR_LEN];
  logic [7:0]  hdr_d [HDR_LEN];
  logic [7:0]  port_q, port_d;
  logic        port_vld_q, port_vld_d;
  logic [15:0] mcast_q, mcast_d;
  logic        mcast_vld_q, mcast_vld_d;
  logic        recirc_q, recirc_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;

  // Byte-array views of the packed inputs/outputs.
  logic [7:0]    arg_b  [ARG_LEN];
  logic [AW-1:0] slot_b [NUM_HDRS];

  for (genvar g = 0; g < ARG_LEN; g++) begin : g_arg
    assign arg_b[g] = bus.args_i[8*g +: 8];
  end
  for (genvar g = 0; g < NUM_HDRS; g++) begin : g_slot
    assign slot_b[g] = bus.parsed_hdrs_i[AW*g +: AW];
  end
  for (genvar g = 0; g < HDR_LEN; g++) begin : g_hdr_out
    assign bus.pkt_hdr_o[8*g +: 8] = hdr_q[g];
  end

  // Op decode.
  logic [5:0]  opc, f1_off, f1_len, f2_off;
  logic [3:0]  f1_hdr, f2_hdr;
  logic [31:0] imm_sx;
  logic        unused_f2_len;

  assign opc           = inst_q[63:58];
  assign imm_sx        = {{6{inst_q[57]}}, inst_q[57:32]};
  assign f1_hdr        = inst_q[31:28];
  assign f1_off        = inst_q[27:22];
  assign f1_len        = inst_q[21:16];
  assign f2_hdr        = inst_q[15:12];
  assign f2_off        = inst_q[11:6];
  assign unused_f2_len = ^inst_q[5:0];

  // Field start addresses and whole-op bounds checks.
  logic [AW:0] f1_start, f2_start;
  int          f1s, f2s, l1;
  logic        f1_oob, src_oob, ck_oob;

  always_comb begin
    f1_start = '0;
    f2_start = '0;
    for (int k = 0; k < NUM_HDRS; k++) begin
      if (f1_hdr == 4'(k)) f1_start = {1'b0, slot_b[k]};
      if (f2_hdr == 4'(k)) f2_start = {1'b0, slot_b[k]};
    end
    f1_start = f1_start + (AW+1)'(f1_off);
    f2_start = f2_start + (AW+1)'(f2_off);
    f1s      = int'(f1_start);
    f2s      = int'(f2_start);
    l1       = int'(f1_len);
    f1_oob   = (f1s + l1) > HDR_LEN;
    src_oob  = (f2_hdr == HDR_PARAM) ? ((int'(f2_off) + l1) > ARG_LEN)
                                     : ((f2s + l1) > HDR_LEN);
    ck_oob   = (f2s + 2) > HDR_LEN;
  end

  // Next-state / datapath.
  logic        op_done, finish, copy_go;
  int          copy_base, cb, idx;
  logic [31:0] add_val;
  logic [15:0] ck_word;
  logic [16:0] ck_sum;

  always_comb begin
    state_d     = state_q;
    ops_d       = ops_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    hdr_d       = hdr_q;
    port_d      = port_q;
    port_vld_d  = port_vld_q;
    mcast_d     = mcast_q;
    mcast_vld_d = mcast_vld_q;
    recirc_d    = recirc_q;
    err_d       = err_q;
    ready_d     = 1'b0;
    op_done     = 1'b0;
    finish      = 1'b0;
    copy_go     = 1'b0;
    copy_base   = 0;
    cb          = int'(cnt_q);
    idx         = 0;
    add_val     = '0;
    ck_word     = '0;
    ck_sum      = '0;

    case (state_q)
      S_IDLE: begin
        // ready_q still high means the previous program's done cycle: busy.
        if (!ready_q) begin
          if (bus.mod_start_i) begin
            for (int k = 0; k < OP_NUM; k++) ops_d[k] = bus.mod_ops_i[64*k +: 64];
          end else if (bus.start_i) begin
            for (int b = 0; b < HDR_LEN; b++) hdr_d[b] = bus.pkt_hdr_i[8*b +: 8];
            inst_d      = ops_q[bus.op_start_i];
            pc_d        = (OW+1)'(bus.op_start_i) + (OW+1)'(1);
            port_d      = '0;
            port_vld_d  = 1'b0;
            mcast_d     = '0;
            mcast_vld_d = 1'b0;
            recirc_d    = 1'b0;
            err_d       = 1'b0;
            state_d     = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        case (opc)
          `OPCODE_NOP: finish = 1'b1;

          `OPCODE_ADD: begin
            if (l1 == 0) begin
              op_done = 1'b1;
            end else if (l1 > 4 || f1_oob) begin
              err_d  = 1'b1;
              finish = 1'b1;
            end else begin
              for (int i = 0; i < 4; i++)
                if (i < l1) add_val = {add_val[23:0], hdr_q[AW'(f1s + i)]};
              add_val = add_val + imm_sx;
              for (int i = 0; i < 4; i++)
                if (i < l1) hdr_d[AW'(f1s + i)] = add_val[8*(l1 - 1 - i) +: 8];
              op_done = 1'b1;
            end
          end

          `OPCODE_COPY_FIELD: begin
            if (f1_oob || src_oob) begin
              err_d  = 1'b1;
              finish = 1'b1;
            end else begin
              copy_go   = 1'b1;
              copy_base = 0;
            end
          end

          `OPCODE_CKSUM: begin
            if (f1_oob || ck_oob) begin
              err_d  = 1'b1;
              finish = 1'b1;
            end else begin
              // Zero the destination first so a checksum field inside the
              // summed range contributes nothing.
              hdr_d[AW'(f2s)]     = 8'h00;
              hdr_d[AW'(f2s + 1)] = 8'h00;
              sum_d   = '0;
              cnt_d   = '0;
              state_d = (l1 == 0) ? S_CKFIN : S_BEAT;
            end
          end

          `OPCODE_SET_PORT: begin
            port_d     = inst_q[39:32];
            port_vld_d = 1'b1;
            op_done    = 1'b1;
          end

          `OPCODE_SET_MULTICAST: begin
            mcast_d     = inst_q[47:32];
            mcast_vld_d = 1'b1;
            op_done     = 1'b1;
          end

          `OPCODE_RECIRCULATE: begin
            recirc_d = 1'b1;
            op_done  = 1'b1;
          end

          default: begin
            err_d  = 1'b1;
            finish = 1'b1;
          end
        endcase
      end

      S_BEAT: begin
        if (opc == `OPCODE_COPY_FIELD) begin
          copy_go   = 1'b1;
          copy_base = cb;
        end else begin
          // Odd trailing byte is padded with 0x00 in the low half.
          ck_word = {hdr_q[AW'(f1s + cb)],
                     ((cb + 1) < l1) ? hdr_q[AW'(f1s + cb + 1)] : 8'h00};
          ck_sum  = {1'b0, sum_q} + {1'b0, ck_word};
          sum_d   = ck_sum[15:0] + {15'd0, ck_sum[16]};
          cnt_d   = 7'(cb + 2);
          if ((cb + 2) >= l1) state_d = S_CKFIN;
        end
      end

      S_CKFIN: begin
        hdr_d[AW'(f2s)]     = ~sum_q[15:8];
        hdr_d[AW'(f2s + 1)] = ~sum_q[7:0];
        op_done             = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // One COPY_FIELD beat; sources come from hdr_q so each beat sees the
    // header as it stood before that beat.
    if (copy_go) begin
      for (int j = 0; j < COPY_BPC; j++) begin
        idx = copy_base + j;
        if (idx < l1) begin
          if (f2_hdr == HDR_PARAM)
            hdr_d[AW'(f1s + idx)] = arg_b[$clog2(ARG_LEN)'(int'(f2_off) + idx)];
          else
            hdr_d[AW'(f1s + idx)] = hdr_q[AW'(f2s + idx)];
        end
      end
      cnt_d = 7'(copy_base + COPY_BPC);
      if ((copy_base + COPY_BPC) >= l1) op_done = 1'b1;
      else                              state_d = S_BEAT;
    end

    // Fetch the next op; running off the end of the table is an implicit NOP.
    if (op_done) begin
      if (pc_q == (OW+1)'(OP_NUM)) begin
        finish = 1'b1;
      end else begin
        inst_d  = ops_q[pc_q[OW-1:0]];
        pc_d    = pc_q + (OW+1)'(1);
        state_d = S_EXEC;
      end
    end

    if (finish) begin
      ready_d = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < OP_NUM; k++) ops_q[k] <= '0;
      for (int b = 0; b < HDR_LEN; b++) hdr_q[b] <= '0;
      inst_q      <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      port_q      <= '0;
      port_vld_q  <= 1'b0;
      mcast_q     <= '0;
      mcast_vld_q <= 1'b0;
      recirc_q    <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ops_q       <= ops_d;
      hdr_q       <= hdr_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      port_q      <= port_d;
      port_vld_q  <= port_vld_d;
      mcast_q     <= mcast_d;
      mcast_vld_q <= mcast_vld_d;
      recirc_q    <= recirc_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.ready_o     = ready_q;
  assign bus.busy_o      = (state_q != S_IDLE) || ready_q;
  assign bus.err_o       = err_q;
  assign bus.port_o      = port_q;
  assign bus.port_vld_o  = port_vld_q;
  assign bus.mcast_o     = mcast_q;
  assign bus.mcast_vld_o = mcast_vld_q;
  assign bus.recirc_o    = recirc_q;
endmodule
